// File: rtl/nibser_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package nibser_pkg;

   localparam int unsigned NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : nibser_pkg

// File: rtl/nibble_serial_addsub_ctrl_add4.sv
// Combinational 4-bit ripple adder; exposes the carry into bit 3 for overflow detection.
module nibble_add4
   import nibser_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             cin,
   output logic [NIB_W-1:0] s,
   output logic             cout,
   output logic             c3
);

   logic [NIB_W:0] c;

   always_comb begin
      s    = '0;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < int'(NIB_W); i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = c[NIB_W];
   assign c3   = c[NIB_W-1];

endmodule : nibble_add4

// File: rtl/nibble_serial_addsub_ctrl.sv
// WIDTH-bit add/subtract sequenced one nibble per clock through a shared 4-bit adder.
// Optional out_zero/out_neg result flags are enabled with `define NIBSER_FLAGS_EN.
module nibble_serial_addsub_ctrl
   import nibser_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_m,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry,
   output logic             out_ovf
`ifdef NIBSER_FLAGS_EN
   ,
   output logic             out_zero,
   output logic             out_neg
`endif
);

   localparam int unsigned NIB   = WIDTH / NIB_W;
   localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam int unsigned LSB_W = $clog2(WIDTH);

   if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("nibble_serial_addsub_ctrl: WIDTH must be a multiple of 4 and >= 8");
   end

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;
   logic               zero_q, zero_d;
   logic               neg_q, neg_d;

   logic [LSB_W-1:0]   nib_lsb;
   logic [NIB_W-1:0]   add_s;
   logic               add_cout;
   logic               add_c3;
   logic               last_nib;

   assign nib_lsb  = LSB_W'(NIB_W * 32'(idx_q));
   assign last_nib = (idx_q == IDX_W'(NIB - 1));

   nibble_add4 u_add4 (
      .a    (a_q[nib_lsb +: NIB_W]),
      .b    (b_q[nib_lsb +: NIB_W]),
      .cin  (carry_q),
      .s    (add_s),
      .cout (add_cout),
      .c3   (add_c3)
   );

   // Next-state, datapath sequencing and result capture
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      neg_d   = neg_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b ^ {WIDTH{in_m}};
               carry_d = in_m;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[nib_lsb +: NIB_W] = add_s;
            carry_d                 = add_cout;
            if (last_nib) begin
               // c3 of the top nibble is the carry into the result MSB
               cout_d  = add_cout;
               ovf_d   = add_c3 ^ add_cout;
               zero_d  = (sum_d == '0);
               neg_d   = sum_d[WIDTH-1];
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
      end
   end

   // Handshake outputs are forced low for as long as reset is held
   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE) && !rst;
   assign out_sum   = sum_q;
   assign out_carry = cout_q;
   assign out_ovf   = ovf_q;

`ifdef NIBSER_FLAGS_EN
   assign out_zero = zero_q;
   assign out_neg  = neg_q;
`else
   logic unused_flags;
   assign unused_flags = zero_q ^ neg_q;
`endif

endmodule : nibble_serial_addsub_ctrl

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Directed self-checking bench for nibble_serial_addsub_ctrl at WIDTH=16.
module tb_nibble_serial_addsub_ctrl;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        in_m;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic        out_carry;
   logic        out_ovf;
`ifdef NIBSER_FLAGS_EN
   logic        out_zero;
   logic        out_neg;
`endif

   int passed;
   int total;

   nibble_serial_addsub_ctrl #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_m      (in_m),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry),
      .out_ovf   (out_ovf)
`ifdef NIBSER_FLAGS_EN
      ,
      .out_zero  (out_zero),
      .out_neg   (out_neg)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one operation and wait for out_valid; returns observed result and latency (0 = timeout).
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic m,
                         output logic [15:0] s, output logic c, output logic o, output int lat);
      for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_m     = m;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = 16'hDEAD;
      in_b     = 16'hBEEF;
      in_m     = ~m;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = n;
            break;
         end
      end
      s = out_sum;
      c = out_carry;
      o = out_ovf;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_m = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
      total++; if (out_sum !== 16'h0000) $display("FAIL reset_out_sum got=%h exp=0000", out_sum); else passed++;
      total++; if ({out_carry, out_ovf} !== 2'b00) $display("FAIL reset_flags got=%b%b exp=00", out_carry, out_ovf); else passed++;
      rst = 1'b0;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); else passed++;
   endtask

   task automatic test_add();
      logic [15:0] s; logic c, o; int lat;
      out_ready = 1'b1;
      run_op(16'h1234, 16'h0FFF, 1'b0, s, c, o, lat);
      total++; if (lat != 5) $display("FAIL add_latency got=%0d exp=5", lat); else passed++;
      total++; if (s !== 16'h2233) $display("FAIL add_sum got=%h exp=2233", s); else passed++;
      total++; if ({c, o} !== 2'b00) $display("FAIL add_carry_ovf got=%b%b exp=00", c, o); else passed++;
      @(negedge clk);
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL add_return_idle got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid); else passed++;
   endtask

   task automatic test_sub();
      logic [15:0] s; logic c, o; int lat;
      out_ready = 1'b1;
      run_op(16'h0005, 16'h0007, 1'b1, s, c, o, lat);
      total++; if (s !== 16'hFFFE) $display("FAIL sub_borrow_sum got=%h exp=fffe", s); else passed++;
      total++; if ({c, o} !== 2'b00) $display("FAIL sub_borrow_carry_ovf got=%b%b exp=00", c, o); else passed++;
      @(negedge clk);
      run_op(16'h0007, 16'h0005, 1'b1, s, c, o, lat);
      total++; if (s !== 16'h0002) $display("FAIL sub_noborrow_sum got=%h exp=0002", s); else passed++;
      total++; if ({c, o} !== 2'b10) $display("FAIL sub_noborrow_carry_ovf got=%b%b exp=10", c, o); else passed++;
      @(negedge clk);
   endtask

   task automatic test_overflow();
      logic [15:0] s; logic c, o; int lat;
      out_ready = 1'b1;
      run_op(16'h7FFF, 16'h0001, 1'b0, s, c, o, lat);
      total++; if (s !== 16'h8000) $display("FAIL ovf_add_sum got=%h exp=8000", s); else passed++;
      total++; if ({c, o} !== 2'b01) $display("FAIL ovf_add_carry_ovf got=%b%b exp=01", c, o); else passed++;
      @(negedge clk);
      run_op(16'h8000, 16'h0001, 1'b1, s, c, o, lat);
      total++; if (s !== 16'h7FFF) $display("FAIL ovf_sub_sum got=%h exp=7fff", s); else passed++;
      total++; if ({c, o} !== 2'b11) $display("FAIL ovf_sub_carry_ovf got=%b%b exp=11", c, o); else passed++;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [15:0] s; logic c, o; int lat;
      out_ready = 1'b0;
      run_op(16'h1111, 16'h2222, 1'b0, s, c, o, lat);
      total++; if (s !== 16'h3333 || lat != 5) $display("FAIL bp_first got sum=%h lat=%0d exp sum=3333 lat=5", s, lat); else passed++;
      in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF; in_m = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 16'h3333 || out_carry !== 1'b0 || out_ovf !== 1'b0)
            $display("FAIL bp_hold cyc=%0d got valid=%b ready=%b sum=%h c=%b o=%b exp valid=1 ready=0 sum=3333 c=0 o=0",
                     i, out_valid, in_ready, out_sum, out_carry, out_ovf);
         else passed++;
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL bp_release got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid); else passed++;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) $display("FAIL bp_not_consumed got ready=%b exp=1", in_ready); else passed++;
   endtask

   task automatic test_reset_midrun();
      logic [15:0] s; logic c, o; int lat; int seen;
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 16'hAAAA; in_b = 16'h5555; in_m = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) $display("FAIL rst_mid_idle got ready=%b exp=1", in_ready); else passed++;
      total++; if (out_sum !== 16'h0000 || out_carry !== 1'b0 || out_ovf !== 1'b0)
         $display("FAIL rst_mid_outputs got sum=%h c=%b o=%b exp sum=0000 c=0 o=0", out_sum, out_carry, out_ovf); else passed++;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) seen++;
         @(negedge clk);
      end
      total++; if (seen != 0) $display("FAIL rst_mid_no_valid got=%0d exp=0", seen); else passed++;
      run_op(16'h0001, 16'h0001, 1'b0, s, c, o, lat);
      total++; if (s !== 16'h0002 || lat != 5) $display("FAIL rst_mid_next got sum=%h lat=%0d exp sum=0002 lat=5", s, lat); else passed++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int acc[$];
      int bad;
      out_ready = 1'b1;
      for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
      in_valid = 1'b1; in_a = 16'h0F0F; in_b = 16'h0101; in_m = 1'b0;
      bad = 0;
      for (int n = 0; n < 20; n++) begin
         if (in_ready) acc.push_back(n);
         if (out_valid && out_sum !== 16'h1010) bad++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      total++; if (acc.size() < 3) $display("FAIL b2b_accepts got=%0d exp>=3", acc.size()); else passed++;
      if (acc.size() >= 3) begin
         total++; if (acc[1] - acc[0] != 6 || acc[2] - acc[1] != 6)
            $display("FAIL b2b_period got=%0d,%0d exp=6,6", acc[1] - acc[0], acc[2] - acc[1]); else passed++;
      end
      total++; if (bad != 0) $display("FAIL b2b_sum got=%0d wrong results exp=0", bad); else passed++;
      for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
      total++; if (in_ready !== 1'b1) $display("FAIL b2b_drain got ready=%b exp=1", in_ready); else passed++;
   endtask

`ifdef NIBSER_FLAGS_EN
   task automatic test_flags();
      logic [15:0] s; logic c, o; int lat;
      out_ready = 1'b1;
      run_op(16'hFFFF, 16'h0001, 1'b0, s, c, o, lat);
      total++; if (s !== 16'h0000 || {c, o} !== 2'b10)
         $display("FAIL flags_wrap got sum=%h c=%b o=%b exp sum=0000 c=1 o=0", s, c, o); else passed++;
      total++; if ({out_zero, out_neg} !== 2'b10) $display("FAIL flags_zero_neg got=%b%b exp=10", out_zero, out_neg); else passed++;
      @(negedge clk);
      run_op(16'h7FFF, 16'h0001, 1'b0, s, c, o, lat);
      total++; if ({out_zero, out_neg} !== 2'b01) $display("FAIL flags_neg got=%b%b exp=01", out_zero, out_neg); else passed++;
      @(negedge clk);
   endtask
`endif

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_add();
      test_sub();
      test_overflow();
      test_backpressure();
      test_reset_midrun();
      test_back_to_back();
`ifdef NIBSER_FLAGS_EN
      test_flags();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_nibble_serial_addsub_ctrl
